// File: rtl/sdram_sched_pkg.sv
// Shared encodings and widths for the SDRAM burst scheduler.
package sdram_sched_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWrReq = 2'd1,
    StRdReq = 2'd2,
    StGap   = 2'd3
  } state_e;

  typedef enum logic {
    GrantWr = 1'b0,
    GrantRd = 1'b1
  } grant_e;

  localparam int unsigned BurstLenDefault = 512;
  localparam int unsigned RowW            = 13;
  localparam int unsigned BankW           = 2;
  // One bit wider than a row so that a quota of 8192 bursts is representable.
  localparam int unsigned CntW            = RowW + 1;

endpackage

// File: rtl/sdram_frame_ptr.sv
// Per-side frame pointer: burst counter, ping-pong buffer bit and quota compare.
module sdram_frame_ptr
  import sdram_sched_pkg::*;
#(
  parameter int unsigned BURSTS_PER_FRAME = 938,
  parameter logic        RESET_BUF        = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            step_i,
  input  logic            sync_i,
  input  logic            next_buf_i,
  output logic [CntW-1:0] cnt_o,
  output logic            buf_o,
  output logic            at_quota_o
);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            buf_d, buf_q;

  always_comb begin
    cnt_d = cnt_q;
    buf_d = buf_q;
    if (sync_i) begin
      cnt_d = '0;
      buf_d = next_buf_i;
    end else if (step_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      buf_q <= RESET_BUF;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign buf_o      = buf_q;
  assign at_quota_o = (cnt_q == CntW'(BURSTS_PER_FRAME));

endmodule

// File: rtl/sdram_burst_sched.sv
// Arbitrates full-page write/read bursts to sdram_ctrl and manages the ping-pong
// frame buffers shared by the camera writer and the display reader.
module sdram_burst_sched
  import sdram_sched_pkg::*;
#(
  parameter int unsigned BURST_LEN        = BurstLenDefault,
  parameter int unsigned FIFO_DEPTH       = 1024,
  parameter int unsigned BURSTS_PER_FRAME = 938,
  parameter int unsigned CNT_W            = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] wr_fifo_used_i,
  input  logic [CNT_W-1:0] rd_fifo_used_i,
  input  logic             wr_vsync_i,
  input  logic             rd_vsync_i,
  input  logic             wr_sdram_ack_i,
  input  logic             rd_sdram_ack_i,
  output logic             wr_sdram_req_o,
  output logic             rd_sdram_req_o,
  output logic [BankW-1:0] wr_bank_o,
  output logic [RowW-1:0]  wr_row_o,
  output logic [BankW-1:0] rd_bank_o,
  output logic [RowW-1:0]  rd_row_o,
  output logic             wr_frame_full_o,
  output logic             sched_busy_o
);

  state_e          state_q;
  grant_e          last_grant_q;
  logic            wr_pend_q, rd_pend_q, done_buf_q, wr_full_q;
  logic            wr_req_q, rd_req_q, busy_q;
  logic [CntW-1:0] wr_cnt, rd_cnt;
  logic            wr_buf, rd_buf, wr_at_quota, rd_at_quota;
  logic            wr_ok, rd_ok, wr_step, rd_step, wr_sync, rd_sync, wr_next_buf;

  // Counters saturate at the quota, so "below quota" is simply "not at quota".
  always_comb begin
    wr_ok       = (32'(wr_fifo_used_i) >= BURST_LEN) && !wr_at_quota;
    rd_ok       = (32'(rd_fifo_used_i) <= FIFO_DEPTH - BURST_LEN) && !rd_at_quota;
    wr_sync     = (state_q == StIdle) && wr_pend_q;
    rd_sync     = (state_q == StIdle) && rd_pend_q;
    wr_step     = (state_q == StWrReq) && wr_sdram_ack_i;
    rd_step     = (state_q == StRdReq) && rd_sdram_ack_i;
    wr_next_buf = wr_at_quota ? ~wr_buf : wr_buf;
  end

  sdram_frame_ptr #(
    .BURSTS_PER_FRAME(BURSTS_PER_FRAME),
    .RESET_BUF       (1'b0)
  ) u_wr_ptr (
    .clk       (clk),
    .rst       (rst),
    .step_i    (wr_step),
    .sync_i    (wr_sync),
    .next_buf_i(wr_next_buf),
    .cnt_o     (wr_cnt),
    .buf_o     (wr_buf),
    .at_quota_o(wr_at_quota)
  );

  sdram_frame_ptr #(
    .BURSTS_PER_FRAME(BURSTS_PER_FRAME),
    .RESET_BUF       (1'b1)
  ) u_rd_ptr (
    .clk       (clk),
    .rst       (rst),
    .step_i    (rd_step),
    .sync_i    (rd_sync),
    .next_buf_i(done_buf_q),
    .cnt_o     (rd_cnt),
    .buf_o     (rd_buf),
    .at_quota_o(rd_at_quota)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= GrantRd;
      wr_pend_q    <= 1'b0;
      rd_pend_q    <= 1'b0;
      done_buf_q   <= 1'b1;
      wr_full_q    <= 1'b0;
      wr_req_q     <= 1'b0;
      rd_req_q     <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      // A vsync arriving while its flag is being applied must survive.
      wr_pend_q <= (wr_pend_q & ~wr_sync) | wr_vsync_i;
      rd_pend_q <= (rd_pend_q & ~rd_sync) | rd_vsync_i;
      unique case (state_q)
        StIdle: begin
          if (wr_pend_q || rd_pend_q) begin
            if (wr_pend_q) begin
              wr_full_q <= 1'b0;
              if (wr_at_quota) done_buf_q <= wr_buf;
            end
          end else if (wr_ok && (!rd_ok || last_grant_q == GrantRd)) begin
            state_q  <= StWrReq;
            wr_req_q <= 1'b1;
            busy_q   <= 1'b1;
          end else if (rd_ok) begin
            state_q  <= StRdReq;
            rd_req_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        StWrReq: begin
          if (wr_sdram_ack_i) begin
            state_q      <= StGap;
            wr_req_q     <= 1'b0;
            busy_q       <= 1'b0;
            last_grant_q <= GrantWr;
            if (wr_cnt == CntW'(BURSTS_PER_FRAME - 1)) wr_full_q <= 1'b1;
          end
        end
        StRdReq: begin
          if (rd_sdram_ack_i) begin
            state_q      <= StGap;
            rd_req_q     <= 1'b0;
            busy_q       <= 1'b0;
            last_grant_q <= GrantRd;
          end
        end
        StGap:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wr_sdram_req_o  = wr_req_q;
  assign rd_sdram_req_o  = rd_req_q;
  assign wr_bank_o       = {{(BankW - 1){1'b0}}, wr_buf};
  assign rd_bank_o       = {{(BankW - 1){1'b0}}, rd_buf};
  assign wr_row_o        = wr_cnt[RowW-1:0];
  assign rd_row_o        = rd_cnt[RowW-1:0];
  assign wr_frame_full_o = wr_full_q;
  assign sched_busy_o    = busy_q;

endmodule

// File: tb/tb_sdram_burst_sched.sv
// Randomized bench for sdram_burst_sched against a burst-level reference model.
module tb_sdram_burst_sched;

  localparam int unsigned Bpf = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] wr_used, rd_used;
  logic        wr_vsync, rd_vsync, wr_ack, rd_ack;
  logic        wr_req, rd_req, wr_full, busy;
  logic [1:0]  wr_bank, rd_bank;
  logic [12:0] wr_row, rd_row;

  always #5 clk = ~clk;

  sdram_burst_sched #(
    .BURST_LEN       (512),
    .FIFO_DEPTH      (1024),
    .BURSTS_PER_FRAME(Bpf),
    .CNT_W           (11)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wr_fifo_used_i (wr_used),
    .rd_fifo_used_i (rd_used),
    .wr_vsync_i     (wr_vsync),
    .rd_vsync_i     (rd_vsync),
    .wr_sdram_ack_i (wr_ack),
    .rd_sdram_ack_i (rd_ack),
    .wr_sdram_req_o (wr_req),
    .rd_sdram_req_o (rd_req),
    .wr_bank_o      (wr_bank),
    .wr_row_o       (wr_row),
    .rd_bank_o      (rd_bank),
    .rd_row_o       (rd_row),
    .wr_frame_full_o(wr_full),
    .sched_busy_o   (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Frame-level model state.
  int m_wr_cnt, m_rd_cnt, m_last;
  bit m_wr_buf, m_rd_buf, m_done, m_full, m_wr_pend, m_rd_pend;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_wr_cnt = 0; m_rd_cnt = 0; m_last = 1;
    m_wr_buf = 0; m_rd_buf = 1; m_done = 1; m_full = 0;
    m_wr_pend = 0; m_rd_pend = 0;
  endtask

  task automatic model_apply_sync();
    if (m_rd_pend) begin
      m_rd_buf = m_done;
      m_rd_cnt = 0;
    end
    if (m_wr_pend) begin
      if (m_wr_cnt == Bpf) begin
        m_done   = m_wr_buf;
        m_wr_buf = !m_wr_buf;
      end
      m_wr_cnt = 0;
      m_full   = 0;
    end
    m_wr_pend = 0;
    m_rd_pend = 0;
  endtask

  initial begin
    int       base, lat, lat_exp, hold, vs_at;
    bit       ok_w, ok_r, go_wr;
    logic [1:0] v;

    rst = 1'b1; wr_used = '0; rd_used = 11'd1024;
    wr_vsync = 1'b0; rd_vsync = 1'b0; wr_ack = 1'b0; rd_ack = 1'b0;
    tick(); tick();
    chk("rst_wr_req", 32'(wr_req), 0);
    chk("rst_rd_req", 32'(rd_req), 0);
    chk("rst_wr_bank", 32'(wr_bank), 0);
    chk("rst_rd_bank", 32'(rd_bank), 1);
    chk("rst_rows", 32'({wr_row, rd_row}), 0);
    chk("rst_full_busy", 32'({wr_full, busy}), 0);

    // Reset during a read burst, followed by a stray ack.
    rst = 1'b0; tick();
    rd_used = 11'd100; tick();
    chk("mid_rd_req_up", 32'(rd_req), 1);
    rst = 1'b1; rd_used = 11'd1024; tick();
    rst = 1'b0;
    chk("mid_rd_req_drop", 32'({rd_req, busy}), 0);
    tick(); tick();
    rd_ack = 1'b1; tick(); rd_ack = 1'b0;
    chk("stray_ack_row", 32'(rd_row), 0);
    chk("stray_ack_req", 32'({wr_req, rd_req}), 0);
    chk("stray_ack_bank", 32'(rd_bank), 1);
    model_reset();

    base = 1;
    for (int r = 0; r < 150; r++) begin
      wr_used = ($urandom_range(0, 1) != 0) ? 11'($urandom_range(512, 1024))
                                            : 11'($urandom_range(0, 511));
      rd_used = ($urandom_range(0, 1) != 0) ? 11'($urandom_range(0, 512))
                                            : 11'($urandom_range(513, 1024));
      lat_exp = base + ((m_wr_pend || m_rd_pend) ? 1 : 0);
      model_apply_sync();
      ok_w = (wr_used >= 11'd512) && (m_wr_cnt < Bpf);
      ok_r = (rd_used <= 11'd512) && (m_rd_cnt < Bpf);
      if (!ok_w && !ok_r) begin
        repeat (lat_exp + 1) tick();
        chk("idle_reqs", 32'({wr_req, rd_req, busy}), 0);
        chk("idle_full", 32'(wr_full), 32'(m_full));
        chk("idle_banks", 32'({wr_bank, rd_bank}), 32'({1'b0, m_wr_buf, 1'b0, m_rd_buf}));
        v = 2'($urandom_range(1, 3));
        wr_vsync = v[0]; rd_vsync = v[1];
        tick();
        wr_vsync = 1'b0; rd_vsync = 1'b0;
        m_wr_pend = v[0]; m_rd_pend = v[1];
        base = 1;
      end else begin
        go_wr = ok_w && (!ok_r || m_last == 1);
        lat = 0;
        while (!(wr_req || rd_req) && lat < 8) begin
          tick();
          lat++;
        end
        chk("grant_latency", 32'(lat), 32'(lat_exp));
        chk("grant_side", 32'({wr_req, rd_req}), 32'({go_wr, !go_wr}));
        chk("grant_busy", 32'(busy), 1);
        if (go_wr) begin
          chk("wr_addr", 32'({wr_bank, wr_row}), 32'({1'b0, m_wr_buf, 13'(m_wr_cnt)}));
        end else begin
          chk("rd_addr", 32'({rd_bank, rd_row}), 32'({1'b0, m_rd_buf, 13'(m_rd_cnt)}));
        end

        hold  = $urandom_range(1, 20);
        vs_at = $urandom_range(0, hold);
        v     = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        for (int i = 0; i <= hold; i++) begin
          wr_vsync = v[0] && (i == vs_at);
          rd_vsync = v[1] && (i == vs_at);
          if (i == hold) begin
            chk("req_held", 32'(go_wr ? wr_req : rd_req), 1);
            chk("row_stable", 32'(go_wr ? wr_row : rd_row),
                32'(go_wr ? m_wr_cnt : m_rd_cnt));
            if (go_wr) wr_ack = 1'b1;
            else       rd_ack = 1'b1;
          end else if ($urandom_range(0, 7) == 0) begin
            if (go_wr) rd_ack = 1'b1;
            else       wr_ack = 1'b1;
          end
          tick();
          wr_vsync = 1'b0; rd_vsync = 1'b0; wr_ack = 1'b0; rd_ack = 1'b0;
        end
        m_wr_pend = m_wr_pend | v[0];
        m_rd_pend = m_rd_pend | v[1];
        if (go_wr) begin
          m_wr_cnt++;
          m_last = 0;
          if (m_wr_cnt == Bpf) m_full = 1;
        end else begin
          m_rd_cnt++;
          m_last = 1;
        end
        chk("gap_reqs", 32'({wr_req, rd_req, busy}), 0);
        chk("gap_rows", 32'({wr_row, rd_row}), 32'({13'(m_wr_cnt), 13'(m_rd_cnt)}));
        chk("gap_full", 32'(wr_full), 32'(m_full));
        base = 2;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
